// File: rtl/rv32_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rv32_pkg
//  Description : Shared RV32 execute-stage types and constants.
//                Holds the divider opcode and state encodings, the divider
//                special-case constants, and the carry-lookahead adder used
//                by the divider subtract path.
//  Revision    : 1.0 - initial release
// ============================================================================
package rv32_pkg;

  // Divider opcode, ordered to match the funct3 low bits of DIV/DIVU/REM/REMU
  typedef enum logic [1:0] {
    DIV_OP_DIV  = 2'b00,
    DIV_OP_DIVU = 2'b01,
    DIV_OP_REM  = 2'b10,
    DIV_OP_REMU = 2'b11
  } div_op_e;

  // Divider control states
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } div_state_e;

  // Dividend that overflows signed division when divided by -1
  localparam logic [31:0] DIV_OVF_DIVIDEND = 32'h8000_0000;
  // Quotient returned for division by zero
  localparam logic [31:0] DIV_BY_ZERO_Q    = '1;

  // Width of the generic adder; callers zero-extend and truncate by cast
  localparam int CLA_W = 64;

  // Generate/propagate adder; subtraction is cla_add(a, ~b, 1'b1)
  function automatic logic [CLA_W-1:0] cla_add(
    input logic [CLA_W-1:0] a,
    input logic [CLA_W-1:0] b,
    input logic             cin
  );
    logic [CLA_W-1:0] g;
    logic [CLA_W-1:0] p;
    logic [CLA_W-1:0] c;
    g    = a & b;
    p    = a ^ b;
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < CLA_W - 1; i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
    end
    return p ^ c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/seq_divider_step.sv
`default_nettype none
// ============================================================================
//  Module      : div_step
//  Description : One radix-2 restoring division iteration. Shifts the next
//                dividend bit into the partial remainder, trial-subtracts the
//                divisor, and keeps the difference when it is non-negative.
//  Revision    : 1.0 - initial release
// ============================================================================
module div_step
  import rv32_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem,
  input  logic            dq_msb,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] next_rem,
  output logic            q_bit
);

  // The shifted remainder keeps its top bit so unsigned divisors at or above
  // 2^(XLEN-1) still compare correctly; the difference carries a sign bit.
  logic [XLEN:0]   w_shifted;
  logic [XLEN+1:0] w_diff;
  logic            w_unused_bits;

  assign w_shifted = {rem, dq_msb};
  assign w_diff    = (XLEN+2)'(cla_add(CLA_W'(w_shifted), ~CLA_W'(divisor), 1'b1));

  // A clear sign bit means the divisor fits: take the difference, emit a 1
  assign q_bit    = ~w_diff[XLEN+1];
  assign next_rem = q_bit ? w_diff[XLEN-1:0] : w_shifted[XLEN-1:0];

  // Bit XLEN of either value is zero whenever it would be selected
  assign w_unused_bits = w_diff[XLEN] ^ w_shifted[XLEN];

endmodule
`default_nettype wire

// File: rtl/seq_divider.sv
`default_nettype none
// ============================================================================
//  Module      : seq_divider
//  Description : Multi-cycle radix-2 restoring divider for RV32M
//                DIV/DIVU/REM/REMU with valid/ready handshakes on both sides.
//                Optional macro DIV_EARLY_OUT_EN: finish immediately when
//                |dividend| < |divisor|.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_divider
  import rv32_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  div_state_e       r_state;
  div_state_e       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  div_op_e          r_op;
  logic [XLEN-1:0]  r_rem;
  logic [XLEN-1:0]  r_dq;
  logic [XLEN-1:0]  r_div_abs;
  logic             r_q_neg;
  logic             r_r_neg;

  logic             w_accept;
  logic             w_signed;
  logic             w_a_neg;
  logic             w_b_neg;
  logic [XLEN-1:0]  w_a_abs;
  logic [XLEN-1:0]  w_b_abs;
  logic             w_div_zero;
  logic             w_ovf;
  logic             w_early;
  logic             w_short;
  logic [XLEN-1:0]  w_short_q;
  logic [XLEN-1:0]  w_short_r;
  logic [XLEN-1:0]  w_step_rem;
  logic             w_step_q;
  logic [XLEN-1:0]  w_q_fix;
  logic [XLEN-1:0]  w_r_fix;
  logic             w_is_rem;

  // ---------------------------------------------------------------- operands
  assign in_ready  = (r_state == IDLE);
  assign busy      = (r_state != IDLE);
  assign out_valid = (r_state == DONE);
  assign w_accept  = in_valid && in_ready && !flush;

  // Signed ops (DIV, REM) have op[0] clear
  assign w_signed   = ~op[0];
  assign w_a_neg    = w_signed & dividend[XLEN-1];
  assign w_b_neg    = w_signed & divisor[XLEN-1];
  assign w_a_abs    = w_a_neg ? -dividend : dividend;
  assign w_b_abs    = w_b_neg ? -divisor  : divisor;
  assign w_div_zero = (divisor == '0);
  assign w_ovf      = w_signed && (dividend == XLEN'(DIV_OVF_DIVIDEND))
                               && (divisor  == XLEN'(DIV_BY_ZERO_Q));

`ifdef DIV_EARLY_OUT_EN
  assign w_early = !w_div_zero && (w_a_abs < w_b_abs);
`else
  assign w_early = 1'b0;
`endif

  assign w_short = w_div_zero | w_ovf | w_early;

  // Quotient/remainder for cases resolved without iterating (early-out default)
  always_comb begin
    w_short_q = '0;
    w_short_r = dividend;
    if (w_div_zero) begin
      w_short_q = XLEN'(DIV_BY_ZERO_Q);
      w_short_r = dividend;
    end else if (w_ovf) begin
      w_short_q = XLEN'(DIV_OVF_DIVIDEND);
      w_short_r = '0;
    end
  end

  // --------------------------------------------------------------- iteration
  div_step #(
    .XLEN (XLEN)
  ) u_div_step (
    .rem      (r_rem),
    .dq_msb   (r_dq[XLEN-1]),
    .divisor  (r_div_abs),
    .next_rem (w_step_rem),
    .q_bit    (w_step_q)
  );

  // ----------------------------------------------------------------- control
  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; flush overrides every handshake
  always_comb begin
    w_state_nxt = r_state;
    if (flush) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (in_valid) w_state_nxt = w_short ? DONE : CALC;
        CALC:    if (r_cnt == '0) w_state_nxt = DONE;
        DONE:    if (out_ready) w_state_nxt = IDLE;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // Operand capture and one quotient bit per CALC cycle into the dq register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_op      <= DIV_OP_DIV;
      r_rem     <= '0;
      r_dq      <= '0;
      r_div_abs <= '0;
      r_q_neg   <= 1'b0;
      r_r_neg   <= 1'b0;
    end else if (flush) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      r_op      <= div_op_e'(op);
      r_div_abs <= w_b_abs;
      r_cnt     <= CNT_W'(XLEN - 1);
      if (w_short) begin
        r_dq    <= w_short_q;
        r_rem   <= w_short_r;
        r_q_neg <= 1'b0;
        r_r_neg <= 1'b0;
      end else begin
        r_dq    <= w_a_abs;
        r_rem   <= '0;
        r_q_neg <= w_a_neg ^ w_b_neg;
        r_r_neg <= w_a_neg;
      end
    end else if (r_state == CALC) begin
      r_rem <= w_step_rem;
      r_dq  <= {r_dq[XLEN-2:0], w_step_q};
      if (r_cnt != '0) r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  // ------------------------------------------------------------- sign fixup
  assign w_q_fix  = r_q_neg ? -r_dq  : r_dq;
  assign w_r_fix  = r_r_neg ? -r_rem : r_rem;
  assign w_is_rem = (r_op == DIV_OP_REM) || (r_op == DIV_OP_REMU);
  assign result   = w_is_rem ? w_r_fix : w_q_fix;

endmodule
`default_nettype wire

// File: tb/tb_seq_divider.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_divider
//  Description : Directed self-checking bench for seq_divider.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_divider;

  localparam logic [1:0] C_DIV  = 2'b00;
  localparam logic [1:0] C_DIVU = 2'b01;
  localparam logic [1:0] C_REM  = 2'b10;
  localparam logic [1:0] C_REMU = 2'b11;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  op;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        busy;

  int total = 0;
  int bad   = 0;

  seq_divider dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one operation, return result and cycles from accept to out_valid
  task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output int cyc);
    int guard;
    guard = 0;
    while (!in_ready && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!in_ready) begin
      total++; bad++;
      $display("FAIL in_ready_timeout: in_ready=%b required 1", in_ready);
    end
    op = o; dividend = a; divisor = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    dividend = $urandom; divisor = $urandom; op = 2'($urandom);
    cyc = 1;
    while (!out_valid && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    res = result;
  endtask

  task automatic ack;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    total++; if (result !== 32'h0) begin bad++; $display("FAIL reset_result: got %h want 00000000", result); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_unsigned;
    logic [31:0] r; int c;
    do_op(C_DIVU, 32'd100, 32'd7, r, c);
    total++; if (r !== 32'd14) begin bad++; $display("FAIL divu_100_7: got %h want %h", r, 32'd14); end
    total++; if (c !== 33) begin bad++; $display("FAIL divu_latency: got %0d want 33", c); end
    ack();
    do_op(C_REMU, 32'd100, 32'd7, r, c);
    total++; if (r !== 32'd2) begin bad++; $display("FAIL remu_100_7: got %h want %h", r, 32'd2); end
    total++; if (c !== 33) begin bad++; $display("FAIL remu_latency: got %0d want 33", c); end
    ack();
    // Divisor above 2^31: partial remainder needs its full width
    do_op(C_DIVU, 32'hFFFF_FFFF, 32'h8000_0001, r, c);
    total++; if (r !== 32'd1) begin bad++; $display("FAIL divu_big: got %h want 00000001", r); end
    ack();
    do_op(C_REMU, 32'hFFFF_FFFF, 32'h8000_0001, r, c);
    total++; if (r !== 32'h7FFF_FFFE) begin bad++; $display("FAIL remu_big: got %h want 7ffffffe", r); end
    ack();
  endtask

  task automatic test_signed;
    logic [31:0] r; int c;
    do_op(C_DIV, -32'sd100, 32'd7, r, c);
    total++; if (r !== 32'hFFFF_FFF2) begin bad++; $display("FAIL div_neg100_7: got %h want fffffff2", r); end
    ack();
    do_op(C_REM, -32'sd100, 32'd7, r, c);
    total++; if (r !== 32'hFFFF_FFFE) begin bad++; $display("FAIL rem_neg100_7: got %h want fffffffe", r); end
    ack();
    do_op(C_REM, 32'd100, -32'sd7, r, c);
    total++; if (r !== 32'd2) begin bad++; $display("FAIL rem_100_neg7: got %h want 00000002", r); end
    ack();
    do_op(C_DIV, 32'd100, -32'sd7, r, c);
    total++; if (r !== 32'hFFFF_FFF2) begin bad++; $display("FAIL div_100_neg7: got %h want fffffff2", r); end
    ack();
  endtask

  task automatic test_special;
    logic [31:0] r; int c;
    do_op(C_DIVU, 32'h1234, 32'h0, r, c);
    total++; if (r !== 32'hFFFF_FFFF) begin bad++; $display("FAIL divu_by_zero: got %h want ffffffff", r); end
    total++; if (c !== 1) begin bad++; $display("FAIL divu_by_zero_lat: got %0d want 1", c); end
    ack();
    do_op(C_REMU, 32'h1234, 32'h0, r, c);
    total++; if (r !== 32'h1234) begin bad++; $display("FAIL remu_by_zero: got %h want 00001234", r); end
    total++; if (c !== 1) begin bad++; $display("FAIL remu_by_zero_lat: got %0d want 1", c); end
    ack();
    do_op(C_DIV, 32'h8000_0000, 32'hFFFF_FFFF, r, c);
    total++; if (r !== 32'h8000_0000) begin bad++; $display("FAIL div_ovf: got %h want 80000000", r); end
    total++; if (c !== 1) begin bad++; $display("FAIL div_ovf_lat: got %0d want 1", c); end
    ack();
    do_op(C_REM, 32'h8000_0000, 32'hFFFF_FFFF, r, c);
    total++; if (r !== 32'h0) begin bad++; $display("FAIL rem_ovf: got %h want 00000000", r); end
    total++; if (c !== 1) begin bad++; $display("FAIL rem_ovf_lat: got %0d want 1", c); end
    ack();
  endtask

  task automatic test_backpressure;
    logic [31:0] r; int c;
    do_op(C_DIVU, 32'd100, 32'd7, r, c);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      total++;
      if (result !== 32'd14 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        bad++;
        $display("FAIL hold_cycle%0d: result=%h out_valid=%b in_ready=%b want 0000000e 1 0",
                 i, result, out_valid, in_ready);
      end
    end
    ack();
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL release: in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_flush;
    logic [31:0] r; int c;
    op = C_DIVU; dividend = 32'hFFFF_FFFF; divisor = 32'd3; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL flush_pre_busy: got %b want 1", busy); end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    total++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL flush_calc: busy=%b out_valid=%b in_ready=%b want 0 0 1", busy, out_valid, in_ready);
    end
    // flush wins over in_valid in IDLE
    op = C_DIVU; dividend = 32'd50; divisor = 32'd5; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL flush_idle_accept: busy=%b want 0", busy); end
    do_op(C_DIVU, 32'd9, 32'd3, r, c);
    total++; if (r !== 32'd3) begin bad++; $display("FAIL after_flush: got %h want 00000003", r); end
    total++; if (c !== 33) begin bad++; $display("FAIL after_flush_lat: got %0d want 33", c); end
    ack();
  endtask

  task automatic test_async_reset;
    logic [31:0] r; int c;
    op = C_DIVU; dividend = 32'd100; divisor = 32'd7; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++;
    if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 32'h0) begin
      bad++;
      $display("FAIL async_reset: busy=%b in_ready=%b out_valid=%b result=%h want 0 1 0 00000000",
               busy, in_ready, out_valid, result);
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    do_op(C_REMU, 32'd23, 32'd5, r, c);
    total++; if (r !== 32'd3) begin bad++; $display("FAIL after_reset: got %h want 00000003", r); end
    ack();
  endtask

  task automatic test_early_out;
    logic [31:0] r; int c; int lat_want;
`ifdef DIV_EARLY_OUT_EN
    lat_want = 1;
`else
    lat_want = 33;
`endif
    do_op(C_DIVU, 32'd5, 32'd9, r, c);
    total++; if (r !== 32'd0) begin bad++; $display("FAIL divu_5_9: got %h want 00000000", r); end
    total++; if (c !== lat_want) begin bad++; $display("FAIL divu_5_9_lat: got %0d want %0d", c, lat_want); end
    ack();
    do_op(C_REMU, 32'd5, 32'd9, r, c);
    total++; if (r !== 32'd5) begin bad++; $display("FAIL remu_5_9: got %h want 00000005", r); end
    ack();
    do_op(C_REM, -32'sd5, 32'd9, r, c);
    total++; if (r !== 32'hFFFF_FFFB) begin bad++; $display("FAIL rem_neg5_9: got %h want fffffffb", r); end
    ack();
  endtask

  task automatic test_back_to_back;
    logic [31:0] r; int c;
    do_op(C_DIVU, 32'd1000, 32'd10, r, c);
    total++; if (r !== 32'd100) begin bad++; $display("FAIL b2b_first: got %h want 00000064", r); end
    out_ready = 1'b1; in_valid = 1'b1; op = C_DIVU; dividend = 32'd77; divisor = 32'd7;
    @(posedge clk); #1;
    out_ready = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_no_same_cycle: busy=%b want 0", busy); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    c = 1;
    while (!out_valid && c < 100) begin @(posedge clk); #1; c++; end
    total++; if (result !== 32'd11) begin bad++; $display("FAIL b2b_second: got %h want 0000000b", result); end
    ack();
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op = 2'b00; dividend = '0; divisor = '0;
    test_reset();
    test_unsigned();
    test_signed();
    test_special();
    test_backpressure();
    test_flush();
    test_async_reset();
    test_early_out();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
